fsm_run_ctrl: RTL and testbench
===============================

Name: fsm_run_ctrl

Overview:
Parametrised run-control state machine, successor to the 2-bit start/stop/mode FSM.
- Adds a multi-bit mode vector, a latched active mode and a run-length counter with optional auto-timeout.
- Adds a timed HALT hold-off, a completion pulse and an asynchronous reset.
- Sits in front of the datapath blocks as their sequencing controller; testbench-driven in unit sim.

Parameters:
- MODE_W, 2: width of mode input and latched mode_q.
- CNT_W, 8: width of the run-length counter run_cnt.
- TIMEOUT, 200: cycles in RUN/ALT before a forced HALT. 0 disables timeout. Must be < 2**CNT_W.
- HOLD, 4: cycles spent in HALT before returning to IDLE. 0 is treated as 1.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: level; request run from IDLE.
- stop, in, 1: level; request halt from RUN/ALT.
- mode, in, MODE_W: 0 selects RUN; any nonzero value selects ALT with that sub-mode.
- state, out, 2: IDLE=2'd0, RUN=2'd1, ALT=2'd2, HALT=2'd3.
- mode_q, out, MODE_W: active sub-mode latched on entry to ALT or on a mode change while in ALT.
- run_cnt, out, CNT_W: cycles spent in RUN/ALT during the current or last run.
- timeout_flag, out, 1: sticky; set when a timeout forces HALT.
- done, out, 1: one-cycle pulse on the HALT->IDLE transition.
- busy, out, 1: registered; high in RUN, ALT and HALT.

Behaviour:
- rst high (asynchronous): state=IDLE, mode_q=0, run_cnt=0, timeout_flag=0, done=0, busy=0, hold counter=0. Applies in any state, mid-run included. First transition is evaluated at the first rising edge after rst falls.
- All outputs are registered. A change on start/stop/mode is visible on state one edge later.
- IDLE:
  - start=1 and stop=0: go to RUN if mode==0, else go to ALT with mode_q<=mode.
  - On that same edge: run_cnt<=0, timeout_flag<=0.
  - start=1 and stop=1: stay IDLE (stop wins).
- RUN/ALT, checked in priority order:
  1. stop=1 -> HALT.
  2. TIMEOUT!=0 and run_cnt==TIMEOUT-1 -> HALT, timeout_flag<=1.
  3. Otherwise, mode selects RUN (mode==0) or ALT (mode!=0). mode_q<=mode whenever the next state is ALT; mode_q holds while in RUN.
- run_cnt:
  - Increments by 1 on every edge where the current state is RUN or ALT, including the exiting edge.
  - Saturates at all-ones; no wrap.
  - Holds its value in HALT and IDLE until the next start.
- start is ignored outside IDLE.
- HALT:
  - Hold counter loads max(HOLD,1)-1 on entry and decrements each cycle.
  - At zero: next state is IDLE and done=1 for exactly that one cycle, coincident with state==IDLE.
  - start, stop and mode are ignored in HALT.
- done and IDLE are mutually exclusive with busy. done never asserts twice per run.
- With TIMEOUT=0, run_cnt saturates at 2**CNT_W-1 and the run continues until stop.

Decomposition:
- Package fsm_run_pkg holds the state enum (IDLE/RUN/ALT/HALT, 2 bits) and the state-encoding localparams shared with the benches and downstream decoders.
- One natural sub-module: fsm_run_timer, a down-counter with load/zero flag used for the HALT hold-off.
- run_cnt stays inline.

Test Plan:
- Bench settings: TIMEOUT=8, HOLD=2, MODE_W=2, CNT_W=8. Cycle N means rising edge N.
- Basic run: start=1, mode=0 at edge 1; stop=1 at edge 5.
  -> state RUN after edge 1, HALT after edge 5, IDLE with done=1 after edge 7.
  -> run_cnt=4, timeout_flag=0.
- Mode switching: start with mode=0, then mode=2'b10 for 2 cycles, then mode=2'b01, then mode=0.
  -> RUN, ALT (mode_q=2), ALT (mode_q=1), RUN.
  -> mode_q holds at 1 after returning to RUN.
- Timeout: start, never stop.
  -> HALT on the edge where run_cnt goes 7->8; timeout_flag=1.
  -> done one cycle after HOLD expires; next start clears timeout_flag.
- Simultaneous events:
  - start=1 and stop=1 in IDLE -> remains IDLE.
  - stop=1 and mode change in RUN -> HALT.
  - start pulse in HALT -> ignored; still IDLE after hold-off.
- Reset mid-operation: assert rst asynchronously between edges while in ALT with run_cnt=5.
  -> all outputs reach reset values before the next edge; no done pulse.
- TIMEOUT=0, CNT_W=3: run 10 cycles.
  -> run_cnt saturates at 7; no forced HALT until stop.

Source files
------------

// File: rtl/fsm_run_pkg.sv
// fsm_run_pkg: state encoding shared by the run controller, benches and decoders
package fsm_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ALT  = 2'd2,
        HALT = 2'd3
    } state_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_ALT  = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

endpackage

// File: rtl/fsm_run_if.sv
// fsm_run_if: command inputs and status outputs of the run controller
interface fsm_run_if #(
    parameter int MODE_W = 2,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              stop;
    logic [MODE_W-1:0] mode;
    logic [1:0]        state;
    logic [MODE_W-1:0] mode_q;
    logic [CNT_W-1:0]  run_cnt;
    logic              timeout_flag;
    logic              done;
    logic              busy;

    modport master (
        output start, stop, mode,
        input  state, mode_q, run_cnt, timeout_flag, done, busy
    );

    modport slave (
        input  start, stop, mode,
        output state, mode_q, run_cnt, timeout_flag, done, busy
    );
endinterface

// File: rtl/fsm_run_timer.sv
// fsm_run_timer: loadable down-counter that parks at zero and flags it
module fsm_run_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    // load wins; otherwise count down until zero and stay there
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= load_i ? val_i : (cnt_q == '0 ? cnt_q : cnt_q - 1'b1);

    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/fsm_run_ctrl.sv
// fsm_run_ctrl: start/stop/mode run controller with run counter, timeout and timed halt
module fsm_run_ctrl
    import fsm_run_pkg::*;
#(
    parameter int MODE_W  = 2,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200,
    parameter int HOLD    = 4
) (
    input  logic      clk,
    input  logic      rst,
    fsm_run_if.slave  bus
);
    localparam int               HOLD_N   = HOLD > 1 ? HOLD : 1;
    localparam int               HOLD_W   = HOLD_N > 1 ? $clog2(HOLD_N) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_N - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d, mode_sel;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tflag_q, tflag_d, done_q, busy_q;
    logic              in_run, hit_to, hold_zero;

    assign in_run   = state_q == RUN || state_q == ALT;
    assign hit_to   = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign mode_sel = bus.mode != '0 ? ALT : RUN;

    // next-state: stop beats timeout beats mode steering; counter saturates while running
    always_comb begin
        state_d = state_q;
        cnt_d   = in_run ? (&cnt_q ? cnt_q : cnt_q + 1'b1) : cnt_q;
        tflag_d = tflag_q;
        case (state_q)
            IDLE: if (bus.start && !bus.stop) begin
                state_d = mode_sel;
                cnt_d   = '0;
                tflag_d = 1'b0;
            end
            RUN, ALT: begin
                state_d = bus.stop || hit_to ? HALT : mode_sel;
                tflag_d = tflag_q | (!bus.stop && hit_to);
            end
            default: state_d = hold_zero ? IDLE : HALT;
        endcase
        mode_d = state_d == ALT ? bus.mode : mode_q;
    end

    // all state and status outputs registered together
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            cnt_q   <= '0;
            tflag_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            tflag_q <= tflag_d;
            done_q  <= state_q == HALT && hold_zero;
            busy_q  <= state_d != IDLE;
        end

    fsm_run_timer #(.W(HOLD_W)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q != HALT && state_d == HALT),
        .val_i  (HOLD_LD),
        .zero_o (hold_zero)
    );

    assign bus.state        = state_q;
    assign bus.mode_q       = mode_q;
    assign bus.run_cnt      = cnt_q;
    assign bus.timeout_flag = tflag_q;
    assign bus.done         = done_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_fsm_run_ctrl.sv
// tb_fsm_run_ctrl: scoreboard bench for the run controller
module tb_fsm_run_ctrl;
    import fsm_run_pkg::*;

    localparam int T_OUT = 8;
    localparam int HLD   = 2;

    typedef struct {
        logic [1:0] st;
        logic [1:0] mq;
        logic [7:0] cnt;
        logic       tf;
        logic       dn;
        logic       bz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    logic [1:0] m_st;
    logic [1:0] m_mq;
    logic [7:0] m_cnt;
    logic       m_tf;
    logic       m_dn;
    int         m_hold;

    fsm_run_if #(.MODE_W(2), .CNT_W(8)) ifa ();
    fsm_run_if #(.MODE_W(2), .CNT_W(3)) ifb ();

    fsm_run_ctrl #(.MODE_W(2), .CNT_W(8), .TIMEOUT(T_OUT), .HOLD(HLD)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    fsm_run_ctrl #(.MODE_W(2), .CNT_W(3), .TIMEOUT(0), .HOLD(HLD)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st   = ST_IDLE;
        m_mq   = '0;
        m_cnt  = '0;
        m_tf   = 1'b0;
        m_dn   = 1'b0;
        m_hold = 0;
    endfunction

    function automatic void model_edge(input logic s, input logic p, input logic [1:0] md);
        logic [1:0] ns;
        ns   = m_st;
        m_dn = 1'b0;
        case (m_st)
            ST_IDLE: if (s && !p) begin
                ns = md == 0 ? ST_RUN : ST_ALT;
                if (md != 0) m_mq = md;
                m_cnt = '0;
                m_tf  = 1'b0;
            end
            ST_RUN, ST_ALT: begin
                if (p) begin
                    ns     = ST_HALT;
                    m_hold = HLD - 1;
                end else if (int'(m_cnt) == T_OUT - 1) begin
                    ns     = ST_HALT;
                    m_tf   = 1'b1;
                    m_hold = HLD - 1;
                end else begin
                    ns = md == 0 ? ST_RUN : ST_ALT;
                    if (md != 0) m_mq = md;
                end
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
            default: if (m_hold == 0) begin
                ns   = ST_IDLE;
                m_dn = 1'b1;
            end else m_hold--;
        endcase
        m_st = ns;
    endfunction

    function automatic void push_exp();
        sb.push_back('{m_st, m_mq, m_cnt, m_tf, m_dn, m_st != ST_IDLE});
    endfunction

    task automatic check_pop();
        exp_t e;
        e = sb.pop_front();
        chk("state", ifa.state, e.st);
        chk("mode_q", ifa.mode_q, e.mq);
        chk("run_cnt", ifa.run_cnt, e.cnt);
        chk("timeout_flag", ifa.timeout_flag, e.tf);
        chk("done", ifa.done, e.dn);
        chk("busy", ifa.busy, e.bz);
    endtask

    task automatic step(input logic s, input logic p, input logic [1:0] md);
        ifa.start = s;
        ifa.stop  = p;
        ifa.mode  = md;
        model_edge(s, p, md);
        push_exp();
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        ifa.start = 1'b0; ifa.stop = 1'b0; ifa.mode = '0;
        ifb.start = 1'b0; ifb.stop = 1'b0; ifb.mode = '0;
        model_reset();
        #12;
        push_exp();
        check_pop();
        rst = 1'b0;
        // basic run: start at edge 1, stop at edge 5, idle with done at edge 7
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        chk("basic_cnt", ifa.run_cnt, 4);
        chk("basic_tf", ifa.timeout_flag, 0);
        // mode switching, then stop with a mode change, start pulses in HALT
        step(1, 0, 0);
        step(0, 0, 2);
        step(0, 0, 2);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("hold_mq", ifa.mode_q, 1);
        step(0, 1, 3);
        step(1, 0, 2);
        step(1, 0, 0);
        step(0, 0, 0);
        // start and stop together in IDLE
        step(1, 1, 1);
        step(0, 0, 0);
        // timeout in ALT, then restart clears the flag
        step(1, 0, 3);
        repeat (8) step(0, 0, 3);
        chk("to_cnt", ifa.run_cnt, 8);
        repeat (3) step(0, 0, 0);
        chk("to_flag", ifa.timeout_flag, 1);
        step(1, 0, 0);
        step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        // asynchronous reset mid-run in ALT with run_cnt=5
        step(1, 0, 1);
        repeat (5) step(0, 0, 1);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        push_exp();
        check_pop();
        ifa.start = 1'b0; ifa.stop = 1'b0; ifa.mode = '0;
        @(posedge clk);
        #1;
        push_exp();
        check_pop();
        rst = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        // no timeout, 3-bit counter saturates at 7
        ifb.start = 1'b1;
        @(posedge clk);
        #1;
        chk("b_start", ifb.state, ST_RUN);
        ifb.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("b_sat", ifb.run_cnt, 7);
        chk("b_no_to", ifb.state, ST_RUN);
        chk("b_tf", ifb.timeout_flag, 0);
        ifb.stop = 1'b1;
        @(posedge clk);
        #1;
        chk("b_stop", ifb.state, ST_HALT);
        chk("b_cnt_hold", ifb.run_cnt, 7);
        ifb.stop = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
